mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store initiator between the CPU MEM stage and a word-organised, handshaked data memory.
- Accepts one byte/half/word access at a time. Generates the word address, byte enables and replicated write data.
- Waits for the memory response, then returns sign- or zero-extended load data.
- Turns misaligned accesses, illegal ops and memory timeouts into an error response instead of a bus access.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_req_valid  in  1  access request from MEM stage
cpu_req_ready  out  1  unit can accept a request this cycle
cpu_op  in  4  [3:1] type: 000 word, 001 byte, 010 half, 011 byteu, 100 halfu; [0] 1 = write
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_rsp_valid  out  1  one-cycle completion pulse
cpu_rsp_err  out  1  qualifies cpu_rsp_valid: access failed, no data
cpu_rdata  out  32  extended load data, valid with cpu_rsp_valid on loads
bus_req_valid  out  1  memory request
bus_req_ready  in  1  memory accepts request
bus_addr  out  32  {addr[31:2],2'b00}
bus_we  out  1  write request
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rsp_valid  in  1  memory completion, one per accepted request (reads and writes)
bus_rdata  in  32  raw word, valid with bus_rsp_valid

Behaviour:
- Reset, asynchronous and active-low: state IDLE. All outputs 0 except cpu_req_ready. In-flight access discarded; bus_req_valid drops immediately. Timeout counter 0.
- FSM IDLE -> REQ -> WAIT -> IDLE. Each access uses its own bus handshake; no pipelining.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch op/addr/wdata and check legality.
  - Legal access -> REQ.
  - Illegal access: cpu_rsp_valid = cpu_rsp_err = 1 on the next cycle, no bus activity, stay in IDLE.
  - Illegal means any of: type 101–111; write with type byteu/halfu; half/halfu with addr[0] = 1; word with addr[1:0] != 0.
- REQ:
  - bus_req_valid = 1. bus_addr, bus_we, bus_be and bus_wdata are held stable until bus_req_ready is sampled 1.
  - On that handshake go to WAIT.
  - cpu_req_ready = 0 in REQ and WAIT.
- Byte enables:
  - word: 1111.
  - byte/byteu: 0001 << addr[1:0].
  - half/halfu: 0011 << addr[1:0] (addr[1:0] is 00 or 10).
  - Reads drive the same bus_be as writes.
- Write data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata unchanged.
- WAIT:
  - On bus_rsp_valid: cpu_rsp_valid = 1, err = 0 next cycle, go to IDLE.
  - Load extraction: lane = bus_rdata byte/half at addr[1:0]. byte/half sign-extend; byteu/halfu zero-extend; word raw.
  - Writes: cpu_rdata = 0.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter clears on entering WAIT and increments each WAIT cycle without bus_rsp_valid.
  - When it reaches TIMEOUT_CYCLES: error response, go to IDLE.
  - bus_rsp_valid in the same cycle as expiry wins, giving a normal response.
- Latency with bus_req_ready = 1 and a same-cycle-next response:
  - Accept edge T0; bus_req_valid high in T0+1.
  - bus_rsp_valid sampled at T0+2 edge; cpu_rsp_valid high in the following cycle.
  - cpu_rsp_valid and cpu_rdata are registered.
- bus_rsp_valid outside WAIT is ignored.
- cpu_rsp_valid and cpu_rsp_err are high for exactly one cycle. cpu_rdata holds its value until the next response.
- The next request is accepted in the same cycle cpu_rsp_valid is high (state already IDLE).

Optional Feature:
- Macro MAU_STORE_TRACE_EN.
- Defined:
  - Adds input cpu_pc[32], latched with the request.
  - On each write bus handshake, calls $display with "%d@%h: *%h <= %h": $time, latched pc, bus_addr, then data:
    - byte: wdata[7:0]
    - half: wdata[15:0]
    - word: wdata[31:0]
- Undefined: no cpu_pc port, no display; logic otherwise identical.

Test Plan:
- Word store 0x1234ABCD to addr 0x10, bus_req_ready = 1 -> bus_addr = 0x10, bus_be = 1111, bus_we = 1, bus_wdata = 0x1234ABCD; cpu_rsp_valid = 1, err = 0 one cycle after bus_rsp_valid.
- Byte loads at addr 0x23 with bus_rdata = 0x80FF7F01:
  - byte -> bus_be = 1000, cpu_rdata = 0xFFFFFF80.
  - byteu -> cpu_rdata = 0x00000080.
- Half store 0xBEEF at addr 0x32 -> bus_be = 1100, bus_wdata = 0xBEEFBEEF, bus_addr = 0x30. Then half load, bus_rdata = 0x8001xxxx -> cpu_rdata = 0xFFFF8001.
- Misaligned and illegal requests -> no bus_req_valid; next-cycle cpu_rsp_valid = err = 1; cpu_req_ready stays 1. Cases:
  - word at 0x02
  - half at 0x01
  - op 4'b0111 (write byteu)
- bus_req_ready held 0 for 5 cycles -> bus signals stable throughout. Then TIMEOUT_CYCLES = 16 with no bus_rsp_valid -> error response exactly 16 WAIT cycles after the handshake.
- reset driven low while in WAIT -> bus_req_valid, cpu_rsp_valid = 0 immediately. A late bus_rsp_valid after reset release -> ignored, no cpu_rsp_valid.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-organised data-memory bus driven by mem_access_unit.
// master = the access unit, slave = the memory.
interface mem_access_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a handshaked word memory.
// Define MAU_STORE_TRACE_EN to add cpu_pc and a $display trace of every store handshake.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [3:0]        cpu_op,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
`ifdef MAU_STORE_TRACE_EN
  input  logic [31:0]       cpu_pc,
`endif
  output logic              cpu_rsp_valid,
  output logic              cpu_rsp_err,
  output logic [31:0]       cpu_rdata,
  mem_access_unit_if.master bus
);

  localparam logic [2:0] TyWord  = 3'd0;
  localparam logic [2:0] TyByte  = 3'd1;
  localparam logic [2:0] TyHalf  = 3'd2;
  localparam logic [2:0] TyByteU = 3'd3;
  localparam logic [2:0] TyHalfU = 3'd4;

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          state_q, state_d;
  logic [2:0]      type_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            latch_en;

  logic [2:0]      req_type;
  logic            req_we;
  logic            req_illegal;
  logic [3:0]      req_be;
  logic [31:0]     req_wdata;
  logic [31:0]     lane;
  logic [31:0]     load_data;

`ifdef MAU_STORE_TRACE_EN
  logic [31:0]     pc_q;
`endif

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    req_type    = cpu_op[3:1];
    req_we      = cpu_op[0];
    req_illegal = 1'b0;
    req_be      = 4'b0000;
    req_wdata   = cpu_wdata;
    unique case (req_type)
      TyWord: begin
        req_be      = 4'b1111;
        req_illegal = (cpu_addr[1:0] != 2'b00);
      end
      TyByte, TyByteU: begin
        req_be      = 4'b0001 << cpu_addr[1:0];
        req_wdata   = {4{cpu_wdata[7:0]}};
        req_illegal = req_we && (req_type == TyByteU);
      end
      TyHalf, TyHalfU: begin
        req_be      = 4'b0011 << cpu_addr[1:0];
        req_wdata   = {2{cpu_wdata[15:0]}};
        req_illegal = cpu_addr[0] || (req_we && (req_type == TyHalfU));
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    unique case (type_q)
      TyByte:  load_data = {{24{lane[7]}}, lane[7:0]};
      TyByteU: load_data = {24'b0, lane[7:0]};
      TyHalf:  load_data = {{16{lane[15]}}, lane[15:0]};
      TyHalfU: load_data = {16'b0, lane[15:0]};
      default: load_data = bus.bus_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    latch_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req_valid) begin
          if (req_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
          end else begin
            latch_en = 1'b1;
            state_d  = StReq;
          end
        end
      end
      StReq: begin
        if (bus.bus_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A response arriving on the expiry cycle still completes normally.
        if (bus.bus_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? '0 : load_data;
          state_d     = StIdle;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CntMax)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rdata_d     = '0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      type_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
`ifdef MAU_STORE_TRACE_EN
      pc_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      if (latch_en) begin
        type_q  <= req_type;
        we_q    <= req_we;
        addr_q  <= cpu_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
`ifdef MAU_STORE_TRACE_EN
        pc_q    <= cpu_pc;
`endif
      end
    end
  end

  assign cpu_req_ready     = (state_q == StIdle);
  assign cpu_rsp_valid     = rsp_valid_q;
  assign cpu_rsp_err       = rsp_err_q;
  assign cpu_rdata         = rdata_q;
  assign bus.bus_req_valid = (state_q == StReq);
  assign bus.bus_addr      = {addr_q[31:2], 2'b00};
  assign bus.bus_we        = we_q;
  assign bus.bus_be        = be_q;
  assign bus.bus_wdata     = wdata_q;

`ifdef MAU_STORE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && (state_q == StReq) && bus.bus_req_ready && we_q) begin
      unique case (type_q)
        TyByte:  $display("%d@%h: *%h <= %h", $time, pc_q, bus.bus_addr, bus.bus_wdata[7:0]);
        TyHalf:  $display("%d@%h: *%h <= %h", $time, pc_q, bus.bus_addr, bus.bus_wdata[15:0]);
        default: $display("%d@%h: *%h <= %h", $time, pc_q, bus.bus_addr, bus.bus_wdata);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model, per-cycle compare process,
// directed cases with literal expectations plus randomized accesses.
module tb_mem_access_unit;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [3:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_err;
  logic [31:0] cpu_rdata;
`ifdef MAU_STORE_TRACE_EN
  logic [31:0] cpu_pc;
`endif

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_op        (cpu_op),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
`ifdef MAU_STORE_TRACE_EN
    .cpu_pc        (cpu_pc),
`endif
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_err   (cpu_rsp_err),
    .cpu_rdata     (cpu_rdata),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          check_en = 1'b0;
  bit          exp_ready, exp_bus_valid, exp_we, exp_rsp_valid, exp_rsp_err, rdata_known;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic [3:0] op);
    int unsigned t = op[3:1];
    if (t == 0) return 4;
    if (t == 1 || t == 3) return 1;
    return 2;
  endfunction

  function automatic bit m_legal(input logic [3:0] op, input logic [31:0] a);
    int unsigned t = op[3:1];
    if (t > 4) return 1'b0;
    if (op[0] && t >= 3) return 1'b0;
    if (a % m_size(op) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int unsigned v = ((1 << m_size(op)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
    if (m_size(op) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (m_size(op) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] lane = rd >> (8 * (a % 4));
    int unsigned t = op[3:1];
    logic [31:0] v;
    if (m_size(op) == 1) begin
      v = lane & 32'hFF;
      if (t == 1 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (m_size(op) == 2) begin
      v = lane & 32'hFFFF;
      if (t == 2 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", {31'b0, cpu_req_ready}, {31'b0, exp_ready});
      chk("bus_req_valid", {31'b0, bus.bus_req_valid}, {31'b0, exp_bus_valid});
      if (exp_bus_valid) begin
        chk("bus_addr", bus.bus_addr, exp_addr);
        chk("bus_we", {31'b0, bus.bus_we}, {31'b0, exp_we});
        chk("bus_be", {28'b0, bus.bus_be}, {28'b0, exp_be});
        chk("bus_wdata", bus.bus_wdata, exp_wdata);
        cap_addr  = bus.bus_addr;
        cap_we    = bus.bus_we;
        cap_be    = bus.bus_be;
        cap_wdata = bus.bus_wdata;
      end
      chk("rsp_valid", {31'b0, cpu_rsp_valid}, {31'b0, exp_rsp_valid});
      if (exp_rsp_valid) chk("rsp_err", {31'b0, cpu_rsp_err}, {31'b0, exp_rsp_err});
      if (rdata_known) chk("rdata", cpu_rdata, exp_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    exp_rsp_valid = 1'b0;
    exp_rsp_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.bus_rsp_valid = 1'($urandom_range(0, 1));
      bus.bus_rdata     = $urandom;
      tick();
    end
    bus.bus_rsp_valid = 1'b0;
  endtask

  // Returns in the cycle the response is visible, so a following call is back-to-back.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int ready_wait, input int rsp_wait, input logic [31:0] rd,
                        input bit to);
    cpu_req_valid     = 1'b1;
    cpu_op            = op;
    cpu_addr          = addr;
    cpu_wdata         = wd;
    bus.bus_rsp_valid = 1'b0;
`ifdef MAU_STORE_TRACE_EN
    cpu_pc            = $urandom;
`endif
    tick();
    cpu_req_valid = 1'b0;
    cpu_op        = 4'($urandom);
    cpu_addr      = $urandom;
    cpu_wdata     = $urandom;
    if (!m_legal(op, addr)) begin
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = 1'b1;
      rdata_known   = 1'b0;
      return;
    end
    exp_ready     = 1'b0;
    exp_bus_valid = 1'b1;
    exp_addr      = addr & 32'hFFFF_FFFC;
    exp_we        = op[0];
    exp_be        = m_be(op, addr);
    exp_wdata     = m_wdata(op, wd);
    bus.bus_req_ready = (ready_wait == 0);
    for (int i = 0; i < ready_wait; i++) begin
      bus.bus_rsp_valid = 1'($urandom_range(0, 1));
      tick();
      if (i == ready_wait - 1) bus.bus_req_ready = 1'b1;
    end
    bus.bus_rsp_valid = 1'($urandom_range(0, 1));
    tick();
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    exp_bus_valid     = 1'b0;
    if (to) begin
      for (int i = 0; i < int'(TO) - 1; i++) tick();
      tick();
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = 1'b1;
      exp_ready     = 1'b1;
      rdata_known   = 1'b0;
    end else begin
      for (int i = 0; i < rsp_wait; i++) tick();
      bus.bus_rsp_valid = 1'b1;
      bus.bus_rdata     = rd;
      tick();
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rdata     = $urandom;
      exp_rsp_valid     = 1'b1;
      exp_ready         = 1'b1;
      exp_rdata         = op[0] ? 32'h0 : m_rdata(op, addr, rd);
      rdata_known       = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    int unsigned t;

    reset             = 1'b0;
    cpu_req_valid     = 1'b0;
    cpu_op            = '0;
    cpu_addr          = '0;
    cpu_wdata         = '0;
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rdata     = '0;
`ifdef MAU_STORE_TRACE_EN
    cpu_pc            = '0;
`endif
    exp_ready = 1'b1; exp_bus_valid = 1'b0; exp_we = 1'b0;
    exp_rsp_valid = 1'b0; exp_rsp_err = 1'b0; rdata_known = 1'b1; exp_rdata = '0;
    exp_addr = '0; exp_wdata = '0; exp_be = '0;
    repeat (2) tick();
    chk("rst_req_ready", {31'b0, cpu_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, cpu_rsp_valid}, 32'd0);
    chk("rst_bus_valid", {31'b0, bus.bus_req_valid}, 32'd0);
    chk("rst_bus_be", {28'b0, bus.bus_be}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    reset    = 1'b1;
    check_en = 1'b1;
    tick();

    // Word store.
    access(4'b0001, 32'h10, 32'h1234_ABCD, 0, 0, 32'h0, 1'b0);
    chk("sw_addr", cap_addr, 32'h10);
    chk("sw_we", {31'b0, cap_we}, 32'd1);
    chk("sw_be", {28'b0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h1234_ABCD);
    chk("sw_rsp", {30'b0, cpu_rsp_valid, cpu_rsp_err}, 32'b10);
    idle(1);

    // Byte loads at 0x23.
    access(4'b0010, 32'h23, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0);
    chk("lb_be", {28'b0, cap_be}, 32'h8);
    chk("lb_rdata", cpu_rdata, 32'hFFFF_FF80);
    access(4'b0110, 32'h23, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0);
    chk("lbu_rdata", cpu_rdata, 32'h0000_0080);
    idle(1);

    // Half store then half load at 0x32.
    access(4'b0101, 32'h32, 32'h0000_BEEF, 1, 2, 32'h0, 1'b0);
    chk("sh_be", {28'b0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", cap_addr, 32'h30);
    access(4'b0100, 32'h32, 32'h0, 0, 1, 32'h8001_1234, 1'b0);
    chk("lh_rdata", cpu_rdata, 32'hFFFF_8001);
    idle(2);

    // Illegal requests.
    access(4'b0000, 32'h02, 32'h0, 0, 0, 32'h0, 1'b0);
    chk("ill_word", {29'b0, cpu_rsp_valid, cpu_rsp_err, cpu_req_ready}, 32'b111);
    access(4'b0100, 32'h01, 32'h0, 0, 0, 32'h0, 1'b0);
    chk("ill_half", {29'b0, cpu_rsp_valid, cpu_rsp_err, cpu_req_ready}, 32'b111);
    access(4'b0111, 32'h00, 32'h0, 0, 0, 32'h0, 1'b0);
    chk("ill_sbu", {29'b0, cpu_rsp_valid, cpu_rsp_err, cpu_req_ready}, 32'b111);
    idle(1);

    // Stalled request then timeout; response exactly on the expiry cycle.
    access(4'b0001, 32'h44, 32'hA5A5_5A5A, 5, 0, 32'h0, 1'b1);
    chk("to_err", {30'b0, cpu_rsp_valid, cpu_rsp_err}, 32'b11);
    idle(1);
    access(4'b0000, 32'h48, 32'h0, 0, int'(TO) - 1, 32'h1357_9BDF, 1'b0);
    chk("to_edge", {30'b0, cpu_rsp_valid, cpu_rsp_err}, 32'b10);
    idle(1);

    // Reset in REQ, in WAIT and in the response cycle; late bus response afterwards.
    for (int v = 0; v < 3; v++) begin
      cpu_req_valid = 1'b1; cpu_op = 4'b0000; cpu_addr = 32'h40; cpu_wdata = 32'hCAFE_0001;
      tick();
      cpu_req_valid = 1'b0;
      exp_ready = 1'b0; exp_bus_valid = 1'b1; exp_addr = 32'h40; exp_we = 1'b0;
      exp_be = 4'hF; exp_wdata = 32'hCAFE_0001;
      bus.bus_req_ready = (v != 0);
      if (v == 0) chk("prerst_bus_valid", {31'b0, bus.bus_req_valid}, 32'd1);
      if (v >= 1) begin
        tick();
        bus.bus_req_ready = 1'b0;
        exp_bus_valid     = 1'b0;
      end
      if (v == 2) begin
        bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'h5555_AAAA;
        tick();
        bus.bus_rsp_valid = 1'b0;
        chk("prerst_rsp_valid", {31'b0, cpu_rsp_valid}, 32'd1);
      end
      check_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("arst_bus_valid", {31'b0, bus.bus_req_valid}, 32'd0);
      chk("arst_rsp_valid", {31'b0, cpu_rsp_valid}, 32'd0);
      chk("arst_req_ready", {31'b0, cpu_req_ready}, 32'd1);
      tick();
      reset = 1'b1;
      exp_ready = 1'b1; exp_bus_valid = 1'b0; rdata_known = 1'b1; exp_rdata = '0;
      check_en = 1'b1;
      bus.bus_rsp_valid = 1'b1; bus.bus_rdata = $urandom;
      tick();
      bus.bus_rsp_valid = 1'b0;
      tick();
    end

    // Randomized accesses.
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom);
      a  = $urandom;
      t  = op[3:1];
      if ($urandom_range(0, 3) != 0) begin
        if (t == 0) a[1:0] = 2'b00;
        else if (t == 2 || t == 4) a[0] = 1'b0;
      end
      access(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, int'(TO) - 1), $urandom,
             ($urandom_range(0, 24) == 0));
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
